// File: rtl/regfile_bypass.sv
// regfile_bypass: NUM_REGS x WIDTH register file with one synchronous write
// port, two combinational read ports, an optional same-cycle write-to-read
// bypass and an optional hardwired-zero register 0.
//
// Port timing: the write is committed at the rising edge of clk. There is no
// handshake. Read data is purely combinational from the read index, the stored
// contents and, when bypassing, the write port of the current cycle.
module regfile_bypass #(
   parameter int WIDTH    = 16,
   parameter int NUM_REGS = 8,
   parameter int ADDR_W   = 3,   // log2(NUM_REGS); every index is therefore legal
   parameter bit BYPASS   = 1'b1,
   parameter bit ZERO_REG = 1'b0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              write_en,
   input  logic [ADDR_W-1:0] write_reg,
   input  logic [WIDTH-1:0]  write_data,
   input  logic [ADDR_W-1:0] read1_reg,
   input  logic [ADDR_W-1:0] read2_reg,
   output logic [WIDTH-1:0]  read1_data,
   output logic [WIDTH-1:0]  read2_data,
   output logic              err
);

   logic [WIDTH-1:0] regs [NUM_REGS];

   // A write aimed at the hardwired-zero register is discarded.
   logic write_to_zero;
   assign write_to_zero = ZERO_REG && (write_reg == '0);

   // Storage: reset clears every entry and wins over a concurrent write.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < NUM_REGS; i++) begin
            regs[i] <= '0;
         end
      end else if (write_en && !write_to_zero) begin
         regs[write_reg] <= write_data;
      end
   end

   // One read port: zero register first, then same-cycle bypass, then storage.
   function automatic logic [WIDTH-1:0] read_port(input logic [ADDR_W-1:0] idx);
      logic [WIDTH-1:0] value;
      value = regs[idx];
      if (BYPASS && !rst && write_en && (write_reg == idx)) begin
         value = write_data;
      end
      if (ZERO_REG && (idx == '0)) begin
         value = '0;
      end
      return value;
   endfunction

   // Read port 1, combinational.
   always_comb begin
      read1_data = read_port(read1_reg);
   end

   // Read port 2, combinational; decides its bypass independently of port 1.
   always_comb begin
      read2_data = read_port(read2_reg);
   end

   // Illegal-access flag. The unknown-input test only has meaning in a
   // four-state simulator; synthesis evaluates it as constant 0, leaving the
   // zero-register write check as the hardware part of this flag.
   always_comb begin
      err = 1'b0;
      if (!rst) begin
         if ($isunknown({write_en, write_reg, write_data, read1_reg, read2_reg})) begin
            err = 1'b1;
         end
         if (write_en && write_to_zero) begin
            err = 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_regfile_bypass.sv
// tb_regfile_bypass: three instances of regfile_bypass (bypass without zero
// register, no bypass with zero register, 32-bit x 16 entries), driven from a
// vector table, a randomized phase against a reference model, and a short
// hand sequence for the wide instance.
module tb_regfile_bypass;

   // ---------------- clock / reset / signals ----------------
   logic        clk;
   logic        rst;
   logic        we;
   logic [2:0]  wr;
   logic [15:0] wd;
   logic [2:0]  r1;
   logic [2:0]  r2;
   logic [15:0] a1, a2, b1, b2;
   logic        a_err, b_err;

   logic        wrst;
   logic        wwe;
   logic [3:0]  wwr;
   logic [31:0] wwd;
   logic [3:0]  wr1;
   logic [3:0]  wr2;
   logic [31:0] w1, w2;
   logic        w_err;

   int checks = 0;
   int errors = 0;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Bypass on, no zero register.
   regfile_bypass #(.WIDTH(16), .NUM_REGS(8), .ADDR_W(3), .BYPASS(1'b1), .ZERO_REG(1'b0)) u_a (
      .clk(clk), .rst(rst), .write_en(we), .write_reg(wr), .write_data(wd),
      .read1_reg(r1), .read2_reg(r2), .read1_data(a1), .read2_data(a2), .err(a_err));

   // Bypass off, hardwired-zero register 0.
   regfile_bypass #(.WIDTH(16), .NUM_REGS(8), .ADDR_W(3), .BYPASS(1'b0), .ZERO_REG(1'b1)) u_b (
      .clk(clk), .rst(rst), .write_en(we), .write_reg(wr), .write_data(wd),
      .read1_reg(r1), .read2_reg(r2), .read1_data(b1), .read2_data(b2), .err(b_err));

   // Wide configuration.
   regfile_bypass #(.WIDTH(32), .NUM_REGS(16), .ADDR_W(4), .BYPASS(1'b1), .ZERO_REG(1'b0)) u_w (
      .clk(clk), .rst(wrst), .write_en(wwe), .write_reg(wwr), .write_data(wwd),
      .read1_reg(wr1), .read2_reg(wr2), .read1_data(w1), .read2_data(w2), .err(w_err));

   // ---------------- reference model ----------------
   // Register contents as the rules define them, one array per configuration.
   logic [15:0] ma [8];
   logic [15:0] mb [8];

   function automatic logic [15:0] exp_a(input logic [2:0] idx);
      if (!rst && we && wr == idx) return wd;
      return ma[idx];
   endfunction

   function automatic logic [15:0] exp_b(input logic [2:0] idx);
      if (idx == 3'd0) return 16'h0000;
      return mb[idx];
   endfunction

   function automatic logic exp_b_err();
      return !rst && we && (wr == 3'd0);
   endfunction

   // ---------------- driver tasks ----------------
   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Present inputs just after a rising edge, then wait to the falling edge.
   task automatic apply(input logic r, input logic w, input logic [2:0] wi,
                        input logic [15:0] wdat, input logic [2:0] ri1, input logic [2:0] ri2);
      rst = r; we = w; wr = wi; wd = wdat; r1 = ri1; r2 = ri2;
      @(negedge clk);
   endtask

   // Commit the rising edge in the model alongside the DUTs.
   task automatic edge_commit();
      @(posedge clk);
      if (rst) begin
         for (int i = 0; i < 8; i++) begin
            ma[i] = 16'h0000;
            mb[i] = 16'h0000;
         end
      end else if (we) begin
         ma[wr] = wd;
         if (wr != 3'd0) mb[wr] = wd;
      end
      #1;
   endtask

   // ---------------- vector table ----------------
   typedef struct {
      logic        rst, we;
      logic [2:0]  wr;
      logic [15:0] wd;
      logic [2:0]  r1, r2;
      logic        chk;
      logic [15:0] a1, a2, b1, b2;
      logic        berr;
   } vec_t;

   vec_t vecs[$];

   function automatic vec_t mk(input logic r, input logic w, input logic [2:0] wi,
                               input logic [15:0] wdat, input logic [2:0] ri1,
                               input logic [2:0] ri2, input logic c,
                               input logic [15:0] ea1, input logic [15:0] ea2,
                               input logic [15:0] eb1, input logic [15:0] eb2,
                               input logic ebe);
      vec_t v;
      v.rst = r; v.we = w; v.wr = wi; v.wd = wdat; v.r1 = ri1; v.r2 = ri2;
      v.chk = c; v.a1 = ea1; v.a2 = ea2; v.b1 = eb1; v.b2 = eb2; v.berr = ebe;
      return v;
   endfunction

   // ---------------- main sequence ----------------
   initial begin
      logic [15:0] pat;
      rst = 1'b1; we = 1'b0; wr = '0; wd = '0; r1 = '0; r2 = '0;
      wrst = 1'b1; wwe = 1'b0; wwr = '0; wwd = '0; wr1 = '0; wr2 = '0;
      for (int i = 0; i < 8; i++) begin
         ma[i] = 16'h0000;
         mb[i] = 16'h0000;
      end

      // Initial reset, then load 1..7 with 1111..7777 (bypass visible on A only).
      vecs.push_back(mk(1, 0, 0, 16'h0000, 0, 0, 0, 0, 0, 0, 0, 0));
      for (int i = 1; i < 8; i++) begin
         pat = 16'(i * 16'h1111);
         vecs.push_back(mk(0, 1, 3'(i), pat, 3'(i), 0, 1, pat, 0, 0, 0, 0));
      end
      // Reset cycle carrying a write: no bypass, stored values still visible, err low.
      vecs.push_back(mk(1, 1, 3, 16'hBEEF, 3, 7, 1, 16'h3333, 16'h7777, 16'h3333, 16'h7777, 0));
      vecs.push_back(mk(0, 0, 0, 16'h0000, 3, 7, 1, 0, 0, 0, 0, 0));
      vecs.push_back(mk(0, 0, 0, 16'h0000, 1, 5, 1, 0, 0, 0, 0, 0));
      // Reload.
      for (int i = 1; i < 8; i++) begin
         pat = 16'(i * 16'h1111);
         vecs.push_back(mk(0, 1, 3'(i), pat, 3'(i), 0, 1, pat, 0, 0, 0, 0));
      end
      // Write/read back.
      vecs.push_back(mk(0, 1, 5, 16'hA5A5, 5, 4, 1, 16'hA5A5, 16'h4444, 16'h5555, 16'h4444, 0));
      vecs.push_back(mk(0, 0, 0, 16'h0000, 5, 5, 1, 16'hA5A5, 16'hA5A5, 16'hA5A5, 16'hA5A5, 0));
      vecs.push_back(mk(0, 0, 0, 16'h0000, 4, 4, 1, 16'h4444, 16'h4444, 16'h4444, 16'h4444, 0));
      // Bypass on one port only.
      vecs.push_back(mk(0, 1, 2, 16'h1234, 2, 6, 1, 16'h1234, 16'h6666, 16'h2222, 16'h6666, 0));
      vecs.push_back(mk(0, 0, 0, 16'h0000, 2, 6, 1, 16'h1234, 16'h6666, 16'h1234, 16'h6666, 0));
      // Write to register 0.
      vecs.push_back(mk(0, 1, 0, 16'hFFFF, 0, 1, 1, 16'hFFFF, 16'h1111, 16'h0000, 16'h1111, 1));
      vecs.push_back(mk(0, 0, 0, 16'h0000, 0, 0, 1, 16'hFFFF, 16'hFFFF, 16'h0000, 16'h0000, 0));

      @(posedge clk);
      #1;
      foreach (vecs[k]) begin
         apply(vecs[k].rst, vecs[k].we, vecs[k].wr, vecs[k].wd, vecs[k].r1, vecs[k].r2);
         if (vecs[k].chk) begin
            check($sformatf("vec%0d a_read1", k), 32'(a1), 32'(vecs[k].a1));
            check($sformatf("vec%0d a_read2", k), 32'(a2), 32'(vecs[k].a2));
            check($sformatf("vec%0d b_read1", k), 32'(b1), 32'(vecs[k].b1));
            check($sformatf("vec%0d b_read2", k), 32'(b2), 32'(vecs[k].b2));
            check($sformatf("vec%0d b_err", k), 32'(b_err), 32'(vecs[k].berr));
            check($sformatf("vec%0d a_err", k), 32'(a_err), 32'(0));
         end
         edge_commit();
      end

      // Hold: write_en low with random address/data; contents must not move.
      for (int n = 0; n < 10; n++) begin
         apply(0, 0, 3'($urandom_range(0, 7)), 16'($urandom), 3'(n % 8), 3'((n + 3) % 8));
         check("hold a_read1", 32'(a1), 32'(exp_a(r1)));
         check("hold b_read2", 32'(b2), 32'(exp_b(r2)));
         check("hold b_err", 32'(b_err), 32'(0));
         edge_commit();
      end
      for (int i = 0; i < 8; i++) begin
         apply(0, 0, 0, 16'h0000, 3'(i), 3'(i));
         check($sformatf("hold_dump a%0d", i), 32'(a1), 32'(exp_a(3'(i))));
         check($sformatf("hold_dump b%0d", i), 32'(b2), 32'(exp_b(3'(i))));
         edge_commit();
      end

      // Randomized phase against the model.
      for (int n = 0; n < 300; n++) begin
         logic        rr, ww;
         logic [2:0]  wi, ri1, ri2;
         rr  = ($urandom_range(0, 15) == 0);
         ww  = $urandom_range(0, 1);
         wi  = 3'($urandom_range(0, 7));
         ri1 = ($urandom_range(0, 3) == 0) ? wi : 3'($urandom_range(0, 7));
         ri2 = ($urandom_range(0, 3) == 0) ? wi : 3'($urandom_range(0, 7));
         apply(rr, ww, wi, 16'($urandom), ri1, ri2);
         check("rand a_read1", 32'(a1), 32'(exp_a(r1)));
         check("rand a_read2", 32'(a2), 32'(exp_a(r2)));
         check("rand b_read1", 32'(b1), 32'(exp_b(r1)));
         check("rand b_read2", 32'(b2), 32'(exp_b(r2)));
         check("rand a_err", 32'(a_err), 32'(0));
         check("rand b_err", 32'(b_err), 32'(exp_b_err()));
         edge_commit();
      end

      // Wide instance: bypass, read back, then reset.
      wrst = 1'b0; wwe = 1'b1; wwr = 4'd15; wwd = 32'hDEADBEEF; wr1 = 4'd14; wr2 = 4'd15;
      @(negedge clk);
      check("wide bypass read2", w2, 32'hDEADBEEF);
      check("wide read1 other", w1, 32'h0);
      @(posedge clk);
      #1;
      wwe = 1'b0; wwd = 32'h0;
      @(negedge clk);
      check("wide readback read2", w2, 32'hDEADBEEF);
      check("wide err", 32'(w_err), 32'(0));
      @(posedge clk);
      #1;
      wrst = 1'b1;
      @(posedge clk);
      #1;
      wrst = 1'b0;
      @(negedge clk);
      check("wide after reset read2", w2, 32'h0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
